// File: rtl/gb_fb_scanout.sv
// gb_fb_scanout: 160x144 2bpp Game Boy framebuffer, PPU capture and DVI scanout.
// Define GB_FB_PALETTE_WR_EN to add a writable palette (pal_we/pal_idx/pal_rgb).
module gb_fb_scanout #(
  parameter int          GB_W       = 160,
  parameter int          GB_H       = 144,
  parameter logic [23:0] BORDER_RGB = 24'h202020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic [1:0]  pix_data,
  input  logic        frame_start,
  output logic        overflow,
  input  logic [7:0]  gb_x,
  input  logic [7:0]  gb_y,
  input  logic        gb_en,
  input  logic        enable,
  input  logic        hs_i,
  input  logic        vs_i,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hs_o,
  output logic        vs_o,
`ifdef GB_FB_PALETTE_WR_EN
  input  logic        pal_we,
  input  logic [1:0]  pal_idx,
  input  logic [23:0] pal_rgb,
`endif
  output logic        de_o
);

  localparam int          LAT   = 3;
  localparam int          DEPTH = GB_W * GB_H;
  localparam logic [14:0] FULL  = 15'(DEPTH);

  function automatic logic [23:0] def_pal(input logic [1:0] s);
    logic [23:0] c;
    c = '0;
    unique case (s)
      2'd0: c = 24'hE0F8D0;
      2'd1: c = 24'h88C070;
      2'd2: c = 24'h346856;
      2'd3: c = 24'h081820;
    endcase
    return c;
  endfunction

  logic [14:0] wr_ptr_q, wr_ptr_d;
  logic        ovf_q, ovf_d;
  logic        we;
  logic [14:0] waddr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    if (frame_start) begin
      ovf_d    = 1'b0;
      waddr    = '0;
      we       = pix_valid;
      wr_ptr_d = pix_valid ? 15'd1 : 15'd0;
    end else if (pix_valid) begin
      if (wr_ptr_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 15'd1;
      end
    end
    we = we & rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  logic [14:0]    addr_q, addr_d;
  logic           win_d;
  logic [1:0]     win_q;
  logic [LAT-1:0] hs_q, vs_q, de_q;

  assign addr_d = {gb_y, 7'b0} + {2'b0, gb_y, 5'b0} + {7'b0, gb_x};
  assign win_d  = gb_en && (gb_x < 8'(GB_W)) && (gb_y < 8'(GB_H));

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      win_q  <= '0;
      hs_q   <= '1;
      vs_q   <= '1;
      de_q   <= '0;
    end else begin
      addr_q <= addr_d;
      win_q  <= {win_q[0], win_d};
      hs_q   <= {hs_q[LAT-2:0], hs_i};
      vs_q   <= {vs_q[LAT-2:0], vs_i};
      de_q   <= {de_q[LAT-2:0], enable};
    end
  end

  // Read-before-write: the read samples the array before this edge's write.
  logic [1:0] mem_q [DEPTH];
  logic [1:0] shade_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= pix_data;
    shade_q <= mem_q[addr_q];
  end

  logic [23:0] lut;

`ifdef GB_FB_PALETTE_WR_EN
  logic [23:0] pal_q [4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) pal_q[i] <= def_pal(2'(i));
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_rgb;
    end
  end

  assign lut = pal_q[shade_q];
`else
  assign lut = def_pal(shade_q);
`endif

  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = '0;
    if (de_q[LAT-2]) rgb_d = win_q[1] ? lut : BORDER_RGB;
  end

  always_ff @(posedge clk) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= rgb_d;
  end

  assign r    = rgb_q[23:16];
  assign g    = rgb_q[15:8];
  assign b    = rgb_q[7:0];
  assign hs_o = hs_q[LAT-1];
  assign vs_o = vs_q[LAT-1];
  assign de_o = de_q[LAT-1];

endmodule

// File: tb/tb_gb_fb_scanout.sv
// tb_gb_fb_scanout: randomized scanout/capture bench against a frame-level model.
// Build with GB_FB_PALETTE_WR_EN to also exercise the writable palette.
module tb_gb_fb_scanout;

  localparam int W = 160;
  localparam int H = 144;
  localparam int N = W * H;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  localparam exp_t RST_E = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, de: 1'b0};

  logic       clk;
  logic       rst;
  logic       pix_valid;
  logic [1:0] pix_data;
  logic       frame_start;
  logic       overflow;
  logic [7:0] gb_x, gb_y;
  logic       gb_en, enable, hs_i, vs_i;
  logic [7:0] r, g, b;
  logic       hs_o, vs_o, de_o;
`ifdef GB_FB_PALETTE_WR_EN
  logic        pal_we;
  logic [1:0]  pal_idx;
  logic [23:0] pal_rgb;
`endif

  gb_fb_scanout dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .overflow    (overflow),
    .gb_x        (gb_x),
    .gb_y        (gb_y),
    .gb_en       (gb_en),
    .enable      (enable),
    .hs_i        (hs_i),
    .vs_i        (vs_i),
    .r           (r),
    .g           (g),
    .b           (b),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
`ifdef GB_FB_PALETTE_WR_EN
    .pal_we      (pal_we),
    .pal_idx     (pal_idx),
    .pal_rgb     (pal_rgb),
`endif
    .de_o        (de_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  mem_m [N];
  logic [23:0] pal_m [4];
  int          wp_m;
  logic        ovf_m;
  exp_t        q[$];
  exp_t        exp_q;

  function automatic logic [23:0] model_rgb();
    if (!enable) return 24'h0;
    if (!(gb_en && gb_x < 8'(W) && gb_y < 8'(H))) return 24'h202020;
    return pal_m[mem_m[int'(gb_y) * W + int'(gb_x)]];
  endfunction

  function automatic logic [26:0] act();
    return {r, g, b, hs_o, vs_o, de_o};
  endfunction

  task automatic set_idle();
    pix_valid   = 1'b0;
    pix_data    = 2'd0;
    frame_start = 1'b0;
    gb_x        = 8'd0;
    gb_y        = 8'd0;
    gb_en       = 1'b0;
    enable      = 1'b0;
    hs_i        = 1'b1;
    vs_i        = 1'b1;
`ifdef GB_FB_PALETTE_WR_EN
    pal_we  = 1'b0;
    pal_idx = 2'd0;
    pal_rgb = 24'h0;
`endif
  endtask

  task automatic read_px(input int x, input int y);
    gb_x   = 8'(x);
    gb_y   = 8'(y);
    gb_en  = 1'b1;
    enable = 1'b1;
  endtask

  // Advance one clock with the currently driven inputs; exp_q is what the
  // outputs should show right after this edge.
  task automatic tick();
    exp_t e;
    if (!rst) begin
      q.delete();
      repeat (3) q.push_back(RST_E);
      wp_m  = 0;
      ovf_m = 1'b0;
      pal_m = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};
    end else begin
`ifdef GB_FB_PALETTE_WR_EN
      if (pal_we) pal_m[pal_idx] = pal_rgb;
`endif
      if (frame_start) begin
        wp_m  = 0;
        ovf_m = 1'b0;
      end
      if (pix_valid) begin
        if (wp_m == N) ovf_m = 1'b1;
        else begin
          mem_m[wp_m] = pix_data;
          wp_m++;
        end
      end
      e.rgb = model_rgb();
      e.hs  = hs_i;
      e.vs  = vs_i;
      e.de  = enable;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    exp_q = q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (act() !== 27'({24'h0, 3'b110})) begin
        n_fail++;
        $display("FAIL reset_state act=%h exp=%h", act(), 27'({24'h0, 3'b110}));
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_tests++;
      if (act() !== exp_q) begin
        n_fail++;
        $display("FAIL reset_refill c%0d act=%h exp=%h", i, act(), exp_q);
      end
      if (i >= 3) begin
        n_tests++;
        if ({r, g, b, de_o} !== {24'h202020, 1'b1}) begin
          n_fail++;
          $display("FAIL reset_border c%0d act=%h%b exp=2020201", i, {r, g, b}, de_o);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_write_path();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      pix_valid = 1'b1;
      pix_data  = 2'(i % 4);
      hs_i      = 1'($urandom);
      tick();
    end
    set_idle();
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_no_ovf act=%b exp=0", overflow);
    end
    read_px(5, 2);
    tick();
    set_idle();
    tick();
    tick();
    n_tests++;
    if ({r, g, b, de_o} !== {24'h88C070, 1'b1} || act() !== exp_q) begin
      n_fail++;
      $display("FAIL wr_read325 act=%h exp=%h", act(), exp_q);
    end
  endtask

  task automatic test_overflow();
    pix_valid = 1'b1;
    pix_data  = 2'd3;
    tick();
    n_tests++;
    if (overflow !== 1'b1 || overflow !== ovf_m) begin
      n_fail++;
      $display("FAIL ovf_set act=%b exp=1", overflow);
    end
    pix_data = 2'd0;
    tick();
    set_idle();
    tick();
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky act=%b exp=1", overflow);
    end
    read_px(W - 1, H - 1);
    tick();
    set_idle();
    tick();
    tick();
    n_tests++;
    if ({r, g, b} !== 24'h081820 || act() !== exp_q) begin
      n_fail++;
      $display("FAIL ovf_last_px act=%h exp=%h", act(), exp_q);
    end
    frame_start = 1'b1;
    tick();
    set_idle();
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear act=%b exp=0", overflow);
    end
    pix_valid = 1'b1;
    pix_data  = 2'd1;
    tick();
    set_idle();
    read_px(0, 0);
    tick();
    set_idle();
    tick();
    tick();
    n_tests++;
    if ({r, g, b} !== 24'h88C070 || act() !== exp_q) begin
      n_fail++;
      $display("FAIL ovf_ptr_zero act=%h exp=%h", act(), exp_q);
    end
  endtask

  task automatic test_alignment();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 39) != 0);
      hs_i   = 1'($urandom);
      vs_i   = 1'($urandom);
      enable = 1'($urandom);
      gb_en  = 1'($urandom);
      gb_x   = 8'($urandom_range(0, W + 10));
      gb_y   = 8'($urandom_range(0, H + 10));
      tick();
      n_tests++;
      if (act() !== exp_q) begin
        n_fail++;
        errs++;
        if (errs < 10) $display("FAIL align c%0d act=%h exp=%h", i, act(), exp_q);
      end
    end
    rst = 1'b1;
    set_idle();
    read_px(W, 3);
    tick();
    set_idle();
    tick();
    tick();
    n_tests++;
    if ({r, g, b, de_o} !== {24'h202020, 1'b1}) begin
      n_fail++;
      $display("FAIL align_x160 act=%h exp=2020201", {r, g, b, de_o});
    end
  endtask

  task automatic test_collision();
    exp_t seen [6];
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 2'd2;
    tick();
    seen[0] = exp_q;
    set_idle();
    tick();
    seen[1] = exp_q;
    read_px(0, 0);
    tick();
    seen[2] = exp_q;
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 2'd3;
    tick();
    seen[3] = exp_q;
    set_idle();
    tick();
    n_tests++;
    if ({r, g, b} !== 24'h346856 || act() !== exp_q) begin
      n_fail++;
      $display("FAIL coll_old act=%h exp=%h", act(), exp_q);
    end
    tick();
    n_tests++;
    if ({r, g, b} !== 24'h081820 || act() !== exp_q) begin
      n_fail++;
      $display("FAIL coll_new act=%h exp=%h", act(), exp_q);
    end
    n_tests++;
    if (seen[2].de !== 1'b0 || seen[3].de !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_model de=%b%b exp=00", seen[2].de, seen[3].de);
    end
  endtask

`ifdef GB_FB_PALETTE_WR_EN
  task automatic test_palette();
    pal_we  = 1'b1;
    pal_idx = 2'd1;
    pal_rgb = 24'hFF0000;
    tick();
    set_idle();
    read_px(1, 0);
    tick();
    set_idle();
    tick();
    tick();
    n_tests++;
    if ({r, g, b} !== 24'hFF0000 || act() !== exp_q) begin
      n_fail++;
      $display("FAIL pal_write act=%h exp=%h", act(), exp_q);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    read_px(1, 0);
    tick();
    set_idle();
    tick();
    tick();
    n_tests++;
    if ({r, g, b} !== 24'h88C070 || act() !== exp_q) begin
      n_fail++;
      $display("FAIL pal_reset act=%h exp=%h", act(), exp_q);
    end
  endtask
`endif

  initial begin
    set_idle();
    rst = 1'b0;
    test_reset();
    test_write_path();
    test_overflow();
    test_alignment();
    test_collision();
`ifdef GB_FB_PALETTE_WR_EN
    test_palette();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_fb_scanout.md
Name: gb_fb_scanout

Overview:
- Dual-role Game Boy framebuffer (160x144, 2 bpp) between the GB PPU pixel stream and the 640x480 DVI timing generator.
- Write side captures PPU pixels in raster order.
- Read side takes the timing generator's gb_x/gb_y/gb_en/enable/hs/vs and returns 24-bit RGB with aligned sync and data-enable to the TMDS encoder.
- Single clock domain; internal inferred simple dual-port RAM.

Parameters:
- GB_W, 160, GB frame width in pixels
- GB_H, 144, GB frame height in lines
- BORDER_RGB, 24'h202020, colour for active DVI area outside the GB window
- LAT, 3, read pipeline depth in cycles (fixed; not a free parameter of the RTL structure)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-low reset
- pix_valid  in  1  PPU pixel strobe
- pix_data  in  2  PPU shade index
- frame_start  in  1  one-cycle pulse, PPU frame begin
- overflow  out  1  sticky: pixel dropped this frame
- gb_x  in  8  GB column from timing generator
- gb_y  in  8  GB line from timing generator
- gb_en  in  1  inside GB window
- enable  in  1  DVI active video
- hs_i  in  1  horizontal sync in
- vs_i  in  1  vertical sync in
- r  out  8  red
- g  out  8  green
- b  out  8  blue
- hs_o  out  1  hs_i delayed LAT
- vs_o  out  1  vs_i delayed LAT
- de_o  out  1  enable delayed LAT

Behaviour:
- Reset (rst==0 at posedge clk):
  - wr_ptr=0, overflow=0, r=g=b=0, hs_o=1, vs_o=1, de_o=0.
  - All pipeline stages flushed to hs=1, vs=1, de=0, border=0.
  - RAM contents are not cleared.
- Write side:
  - On pix_valid, write pix_data to RAM[wr_ptr]; wr_ptr is 15 bits.
  - wr_ptr increments per write and saturates at GB_W*GB_H (23040).
  - A write with wr_ptr==23040 is dropped and sets overflow.
  - frame_start sets wr_ptr to 0 and clears overflow.
  - frame_start and pix_valid in the same cycle: the pixel goes to address 0, and wr_ptr becomes 1.
- Read pipeline, 3 cycles:
  - S1 registers addr = gb_y*GB_W + gb_x (15-bit, multiply as shift-add: y*128 + y*32 + x). It also registers inwin = gb_en && gb_x<GB_W && gb_y<GB_H, plus de/hs/vs.
  - S2 performs the synchronous RAM read.
  - S3 palette lookup. Outputs:
    - de=0: RGB=0.
    - de=1 and !inwin: RGB=BORDER_RGB.
    - de=1 and inwin: RGB=palette[shade].
- hs_o/vs_o/de_o equal hs_i/vs_i/enable sampled exactly 3 clocks earlier.
- Same-address read and write in one cycle: the read returns the old data (read-before-write).
- Default palette:
  - shade 0 = E0F8D0
  - shade 1 = 88C070
  - shade 2 = 346856
  - shade 3 = 081820
- Reset asserted mid-line: outputs go to reset values on the next edge. The pipeline refills within 3 cycles of release; no spurious de_o=1 during refill.

Optional Feature:
- Macro GB_FB_PALETTE_WR_EN.
- When defined, adds ports:
  - pal_we  in  1
  - pal_idx  in  2
  - pal_rgb  in  24
- pal_we writes palette[pal_idx] on that edge. Reset restores the default palette.
- A write colliding with an S3 lookup of the same index shows the old colour this cycle and the new colour from the next cycle.
- When undefined, the palette is the constant default and the ports are absent.

Test Plan:
- Reset then idle: rst=0 for 2 cycles -> r=g=b=0, hs_o=1, vs_o=1, de_o=0. After release with enable=1, gb_en=0 held -> de_o=1 and RGB=202020 from the 3rd cycle on.
- Write path: frame_start, then 23040 pix_valid with pix_data=(index mod 4); read gb_x=5, gb_y=2 (addr 325, data 1) with enable=gb_en=1 -> RGB=88C070 exactly 3 cycles later.
- Overflow: after 23040 writes, one more pix_valid with data 3 -> overflow=1 and RAM[23039] unchanged. frame_start -> overflow=0, wr_ptr=0.
- Alignment: toggle hs_i/vs_i/enable with a random pattern -> outputs match the inputs delayed exactly 3 cycles. With gb_x=160, gb_en=1 -> border colour.
- Collision: frame_start+pix_valid (data 2) in one cycle -> RAM[0]=2. A read of addr 0 in the same cycle as a write of data 3 -> old value returned, new value on the next read.
- With GB_FB_PALETTE_WR_EN: pal_we, idx 1, FF0000, then read a shade-1 pixel -> RGB=FF0000. Reset -> the shade-1 pixel reads 88C070 again.
